// File: rtl/alu_seq_pkg.sv
// Shared opcode map, handshake FSM states and helpers for the sequential ALU.
package alu_seq_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;

    // SLT compares through the subtract path so it can use sign XOR overflow.
    function automatic logic op_uses_sub(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_seq_div.sv
// Restoring unsigned divider, one quotient bit per cycle, WIDTH iterations per division.
module alu_seq_div #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quot
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_div;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_unused_bits;

    // r_quot starts as the dividend and fills with quotient bits as dividend bits shift out.
    assign w_shift       = {r_rem, r_quot[WIDTH-1]};
    assign w_sub         = {1'b0, w_shift} - {2'b00, r_div};
    assign w_ge          = ~w_sub[WIDTH+1];
    assign w_rem_next    = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_unused_bits = w_sub[WIDTH] ^ w_shift[WIDTH];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quot <= '0;
            r_div  <= '0;
        end else if (i_start && !r_busy) begin
            r_busy <= 1'b1;
            r_cnt  <= CNT_W'(WIDTH - 1);
            r_rem  <= '0;
            r_quot <= i_a;
            r_div  <= i_b;
        end else if (r_busy) begin
            r_rem  <= w_rem_next;
            r_quot <= {r_quot[WIDTH-2:0], w_ge};
            r_cnt  <= r_cnt - CNT_W'(1);
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end
        end
    end

    // o_done marks the final iteration; o_rem/o_quot are the values that iteration produces.
    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == '0);
    assign o_rem  = w_rem_next;
    assign o_quot = {r_quot[WIDTH-2:0], w_ge};

endmodule

// File: rtl/alu_seq_param.sv
// Registered-output parametrised ALU with valid/ready input and a restoring-divider MOD.
// Define ALU_SEQ_QUOT_EN to add the Quot output carrying the MOD quotient.
module alu_seq_param
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUOp,
    output logic [WIDTH-1:0] Result,
    output logic             C,
    output logic             Div0,
`ifdef ALU_SEQ_QUOT_EN
    output logic             We,
    output logic [WIDTH-1:0] Quot
`else
    output logic             We
`endif
);

    state_e           r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_c;
    logic             r_div0;
    logic             r_we;

    logic             w_accept;
    logic             w_is_mod;
    logic             w_b_zero;
    logic             w_div_start;
    logic             w_div_busy;
    logic             w_div_done;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quot;
    logic             w_sub_op;
    logic [WIDTH-1:0] w_b_op;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic             w_slt;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c;
    logic             w_unused_div;

    assign In_Ready    = (r_state == IDLE);
    assign w_accept    = In_Valid & In_Ready;
    assign w_is_mod    = (ALUOp == OP_MOD);
    assign w_b_zero    = (B == '0);
    assign w_div_start = w_accept & w_is_mod & ~w_b_zero;

    assign w_sub_op = op_uses_sub(ALUOp);
    assign w_b_op   = w_sub_op ? ~B : B;
    assign w_sum    = {1'b0, A} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_sub_op};
    assign w_ovf    = (A[WIDTH-1] ^ B[WIDTH-1]) & (A[WIDTH-1] ^ w_sum[WIDTH-1]);
    assign w_slt    = w_sum[WIDTH-1] ^ w_ovf;

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        case (ALUOp)
            OP_AND: w_alu_res = A & B;
            OP_OR:  w_alu_res = A | B;
            OP_XOR: w_alu_res = A ^ B;
            OP_NOR: w_alu_res = ~(A | B);
            OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
            OP_ADD, OP_SUB: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
            end
            default: ;
        endcase
    end

    alu_seq_div #(
        .WIDTH (WIDTH)
    ) u_div (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_start (w_div_start),
        .i_a     (A),
        .i_b     (B),
        .o_busy  (w_div_busy),
        .o_done  (w_div_done),
        .o_rem   (w_div_rem),
        .o_quot  (w_div_quot)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_c      <= 1'b0;
            r_div0   <= 1'b0;
            r_we     <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (!w_is_mod) begin
                            r_result <= w_alu_res;
                            r_c      <= w_alu_c;
                            r_div0   <= 1'b0;
                            r_we     <= 1'b1;
                        end else if (w_b_zero) begin
                            r_result <= A;
                            r_c      <= 1'b0;
                            r_div0   <= 1'b1;
                            r_we     <= 1'b1;
                        end else begin
                            r_state <= DIV;
                        end
                    end
                end
                DIV: begin
                    if (w_div_done) begin
                        r_result <= w_div_rem;
                        r_c      <= 1'b0;
                        r_div0   <= 1'b0;
                        r_we     <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Result = r_result;
    assign C      = r_c;
    assign Div0   = r_div0;
    assign We     = r_we;

`ifdef ALU_SEQ_QUOT_EN
    logic [WIDTH-1:0] r_quot;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_quot <= '0;
        end else if ((r_state == IDLE) && w_accept && w_is_mod && w_b_zero) begin
            r_quot <= '1;
        end else if ((r_state == DIV) && w_div_done) begin
            r_quot <= w_div_quot;
        end
    end

    assign Quot         = r_quot;
    assign w_unused_div = w_div_busy;
`else
    assign w_unused_div = w_div_busy ^ (^w_div_quot);
`endif

endmodule
